slice_column_scheduler: RTL
===========================

Name: slice_column_scheduler

Overview:
- Sequences the slice-height calculator across every screen column of one frame.
- On a frame start, snapshots the player pose and issues one calculation per column, 0..NUM_COLS-1.
- Clamps each result and hands it to the column drawer through a valid/ready output register.
- Sits between the game-state registers, the slice-height calculator and the VGA slice drawer.

Parameters:
- NUM_COLS, 160: columns per frame; legal range 1..256.
- MAX_HEIGHT, 120: clamp ceiling applied to the returned slice height.
- CALC_TIMEOUT, 255: cycles to wait for calc_end before abandoning a column (used only with TIMEOUT_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_frame  in  1  request to process a new frame.
- player_x_in  in  13 signed  player X position.
- player_y_in  in  13 signed  player Y position.
- angle_x_in  in  10 signed  view angle, integer part.
- angle_y_in  in  10 signed  view angle, fraction part.
- busy  out  1  high from frame acceptance until frame_done.
- frame_done  out  1  one-cycle pulse after the last column is handed off.
- calc_player_x, calc_player_y  out  13 signed  latched pose sent to the calculator.
- calc_angle_x, calc_angle_y  out  10 signed  latched angle sent to the calculator.
- calc_column  out  8  column index sent to the calculator.
- calc_begin  out  1  one-cycle start pulse to the calculator.
- calc_end  in  1  calculator completion.
- calc_slice_size  in  7  calculator result, valid while calc_end is high.
- draw_valid  out  1  output register holds a column.
- draw_ready  in  1  drawer accepts the column.
- draw_column  out  8  column index of the held result.
- draw_height  out  7  clamped height of the held result.
- timeout_err  out  1  sticky flag: a column timed out.

Behaviour:
- Reset: all outputs and registers go to 0 immediately and asynchronously; state becomes S_IDLE. Reset asserted mid-frame abandons the frame; no frame_done is produced.
- S_IDLE:
  - start_frame=1 latches the four pose/angle inputs into the calc_* registers, sets column counter to 0 and busy=1, then goes to S_ISSUE.
  - start_frame while busy is ignored.
- S_ISSUE: calc_begin=1 for exactly this one cycle with calc_column = counter; go to S_WAIT.
- S_WAIT:
  - Waits for calc_end=1.
  - calc_end arriving in any other state is ignored.
  - Result h = min(calc_slice_size, MAX_HEIGHT), compared unsigned.
  - If the output register is free, load it and go to S_NEXT. "Free" means draw_valid=0, or draw_valid=1 and draw_ready=1 in the same cycle; the simultaneous handoff-and-load is lossless.
  - Otherwise store h in a hold register and go to S_HOLD.
- S_HOLD: load the held result into the output register in the first cycle the register is free, then go to S_NEXT.
- S_NEXT:
  - If counter = NUM_COLS-1, go to S_DRAIN.
  - Otherwise increment the counter and go to S_ISSUE. The next calculation overlaps with the drawer consuming the previous column.
- S_DRAIN: wait until draw_valid=0 or a handshake completes this cycle, then go to S_DONE.
- S_DONE: frame_done=1 for one cycle, busy=0, return to S_IDLE.
- Output register:
  - draw_valid rises on load.
  - draw_column and draw_height stay stable while draw_valid=1 and draw_ready=0.
  - draw_valid falls after a handshake unless reloaded in the same cycle.
- Latency: from calc_end to draw_valid is 1 cycle when the register is free. Best-case throughput per column is 3 cycles plus calculator latency.
- Pose inputs may change freely while busy; only the latched values are used.
- Counter width is 8 bits; NUM_COLS=256 must terminate at column 255 with no wrap.

Optional Feature:
- TIMEOUT_EN defined:
  - An 8-bit wait counter runs in S_WAIT.
  - After CALC_TIMEOUT cycles with no calc_end, the column completes with h=0 and timeout_err is set. timeout_err clears only on reset.
  - calc_end in the expiry cycle takes priority over the timeout.
- TIMEOUT_EN undefined: S_WAIT waits indefinitely; timeout_err is tied to 0.

Test Plan:
- NUM_COLS=4, draw_ready held 1, calculator answers 5 cycles after each begin with heights 10,20,30,40:
  - exactly 4 calc_begin pulses, columns 0..3;
  - draw outputs (0,10),(1,20),(2,30),(3,40);
  - one frame_done pulse; busy low afterwards.
- Calculator returns 127 -> draw_height=120; returns 120 -> 120; returns 0 -> 0.
- draw_ready held 0 for 40 cycles during the frame:
  - column 0 is held stable;
  - column 1 waits in S_HOLD and no third calc_begin is issued;
  - after release, columns arrive in order with no loss or duplication.
- start_frame pulsed mid-frame, with pose inputs changed to X=100 while the latched value is 50 -> ignored; calc_player_x stays 50.
- Reset asserted while in S_WAIT with column 2 pending -> all outputs 0 in the same cycle; a fresh start_frame restarts at column 0.
- With TIMEOUT_EN, CALC_TIMEOUT=8, calculator silent on column 1 -> after 8 cycles draw (1,0) is produced, timeout_err=1, and the frame completes.

Source files
------------

// File: rtl/slice_column_scheduler_if.sv
// Bus bundle between the column scheduler and its neighbours: frame control
// and pose from the game-state registers, the slice-height calculator
// handshake, and the valid/ready channel into the VGA slice drawer.
// slave  : scheduler side
// master : environment side (game state, calculator, drawer)
interface slice_column_scheduler_if;
    logic               start_frame;
    logic signed [12:0] player_x_in;
    logic signed [12:0] player_y_in;
    logic signed [9:0]  angle_x_in;
    logic signed [9:0]  angle_y_in;
    logic               busy;
    logic               frame_done;
    logic signed [12:0] calc_player_x;
    logic signed [12:0] calc_player_y;
    logic signed [9:0]  calc_angle_x;
    logic signed [9:0]  calc_angle_y;
    logic [7:0]         calc_column;
    logic               calc_begin;
    logic               calc_end;
    logic [6:0]         calc_slice_size;
    logic               draw_valid;
    logic               draw_ready;
    logic [7:0]         draw_column;
    logic [6:0]         draw_height;
    logic               timeout_err;

    modport slave (
        input  start_frame, player_x_in, player_y_in, angle_x_in, angle_y_in,
        input  calc_end, calc_slice_size, draw_ready,
        output busy, frame_done,
        output calc_player_x, calc_player_y, calc_angle_x, calc_angle_y,
        output calc_column, calc_begin,
        output draw_valid, draw_column, draw_height, timeout_err
    );

    modport master (
        output start_frame, player_x_in, player_y_in, angle_x_in, angle_y_in,
        output calc_end, calc_slice_size, draw_ready,
        input  busy, frame_done,
        input  calc_player_x, calc_player_y, calc_angle_x, calc_angle_y,
        input  calc_column, calc_begin,
        input  draw_valid, draw_column, draw_height, timeout_err
    );
endinterface

// File: rtl/slice_column_scheduler.sv
// Column scheduler: snapshots the pose at frame start, runs the slice-height
// calculator once per column, clamps each height and hands it to the drawer
// through a one-entry valid/ready output register plus a one-entry hold slot.
// Optional macro TIMEOUT_EN: abandon a column after CALC_TIMEOUT silent
// cycles, emit height 0 and raise the sticky timeout_err flag.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no frame; waiting for start_frame
// S_ISSUE | calc_begin pulse for the current column
// S_WAIT  | waiting for calc_end (or timeout)
// S_HOLD  | result parked in the hold slot until the output register frees
// S_NEXT  | advance to the next column or finish
// S_DRAIN | last column loaded; wait for the drawer to take it
// S_DONE  | frame_done pulse
module slice_column_scheduler #(
    parameter int NUM_COLS     = 160,
    parameter int MAX_HEIGHT   = 120,
    parameter int CALC_TIMEOUT = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    slice_column_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_NEXT, S_DRAIN, S_DONE
    } state_t;

    localparam logic [7:0] LP_LAST_COL = 8'(NUM_COLS - 1);
    localparam logic [6:0] LP_MAX_H    = 7'(MAX_HEIGHT);

    if (NUM_COLS < 1 || NUM_COLS > 256 || MAX_HEIGHT < 0 || MAX_HEIGHT > 127 ||
        CALC_TIMEOUT < 1 || CALC_TIMEOUT > 255) begin : g_bad_param
        $error("slice_column_scheduler: parameter out of range");
    end

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_col;
    logic signed [12:0] r_px, r_py;
    logic signed [9:0]  r_ax, r_ay;
    logic               r_draw_valid;
    logic [7:0]         r_draw_col;
    logic [6:0]         r_draw_h;
    logic [6:0]         r_hold_h;
    logic               w_free;
    logic               w_result;
    logic               w_expired;
    logic               w_load;
    logic               w_timeout_err;
    logic [6:0]         w_clamp_h;
    logic [6:0]         w_result_h;
    logic [6:0]         w_load_h;

    // A handoff and a reload in the same cycle is lossless, so a register
    // being drained this cycle already counts as free.
    assign w_free     = !r_draw_valid || bus.draw_ready;
    assign w_clamp_h  = (bus.calc_slice_size > LP_MAX_H) ? LP_MAX_H : bus.calc_slice_size;
    assign w_result   = (r_state == S_WAIT) && (bus.calc_end || w_expired);
    assign w_result_h = bus.calc_end ? w_clamp_h : 7'd0;

`ifdef TIMEOUT_EN
    localparam logic [7:0] LP_TMO_LOAD = 8'(CALC_TIMEOUT - 1);
    logic [7:0] r_wait_cnt;
    logic       r_timeout_err;

    // calc_end in the terminal cycle wins over the timeout.
    assign w_expired     = (r_state == S_WAIT) && !bus.calc_end && (r_wait_cnt == 8'd0);
    assign w_timeout_err = r_timeout_err;

    // Wait timer reloads on every issue and counts down while waiting; the error flag is sticky.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= LP_TMO_LOAD;
            end else if (r_state == S_WAIT && r_wait_cnt != 8'd0) begin
                r_wait_cnt <= r_wait_cnt - 8'd1;
            end
            if (w_expired) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_expired     = 1'b0;
    assign w_timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and output-register load decision.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_load_h = r_hold_h;
        case (r_state)
            S_IDLE:  if (bus.start_frame) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_result) begin
                    if (w_free) begin
                        w_load   = 1'b1;
                        w_load_h = w_result_h;
                        w_next   = S_NEXT;
                    end else begin
                        w_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_free) begin
                    w_load = 1'b1;
                    w_next = S_NEXT;
                end
            end
            S_NEXT:  w_next = (r_col == LP_LAST_COL) ? S_DRAIN : S_ISSUE;
            S_DRAIN: if (w_free) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pose snapshot, column counter, hold slot and drawer output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col        <= 8'd0;
            r_px         <= '0;
            r_py         <= '0;
            r_ax         <= '0;
            r_ay         <= '0;
            r_hold_h     <= 7'd0;
            r_draw_valid <= 1'b0;
            r_draw_col   <= 8'd0;
            r_draw_h     <= 7'd0;
        end else begin
            if (r_state == S_IDLE && bus.start_frame) begin
                r_px  <= bus.player_x_in;
                r_py  <= bus.player_y_in;
                r_ax  <= bus.angle_x_in;
                r_ay  <= bus.angle_y_in;
                r_col <= 8'd0;
            end else if (r_state == S_NEXT && r_col != LP_LAST_COL) begin
                r_col <= r_col + 8'd1;
            end

            if (w_result && !w_free) begin
                r_hold_h <= w_result_h;
            end

            if (w_load) begin
                r_draw_valid <= 1'b1;
                r_draw_col   <= r_col;
                r_draw_h     <= w_load_h;
            end else if (bus.draw_ready) begin
                r_draw_valid <= 1'b0;
            end
        end
    end

    assign bus.busy          = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.frame_done    = (r_state == S_DONE);
    assign bus.calc_begin    = (r_state == S_ISSUE);
    assign bus.calc_column   = r_col;
    assign bus.calc_player_x = r_px;
    assign bus.calc_player_y = r_py;
    assign bus.calc_angle_x  = r_ax;
    assign bus.calc_angle_y  = r_ay;
    assign bus.draw_valid    = r_draw_valid;
    assign bus.draw_column   = r_draw_col;
    assign bus.draw_height   = r_draw_h;
    assign bus.timeout_err   = w_timeout_err;
endmodule
